alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_decode.sv | 99 +++++++++
 rtl/alu_issue_stage.sv | 67 ++++++
 tb/tb_alu_issue_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and RV32I encoding constants, used by the issue stage and the ALU.
package alu_pkg;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SLL  = 5'b00001,
      ALU_XOR  = 5'b00100,
      ALU_SRL  = 5'b00101,
      ALU_OR   = 5'b00110,
      ALU_AND  = 5'b00111,
      ALU_SUB  = 5'b01010,
      ALU_SRA  = 5'b01011,
      ALU_SLT  = 5'b01100,
      ALU_SLTU = 5'b01110
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Operation selected by funct3 alone when funct7 is the base encoding.
   function automatic alu_op_e f3_base_op(input logic [2:0] funct3);
      alu_op_e op;
      case (funct3)
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer-ALU decode: operands, ALU opcode, destination and illegal flag.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [4:0]  op,
   output logic [4:0]  rd,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] a_t;
   logic [31:0] b_t;
   alu_op_e     op_t;
   logic        legal;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};

   always_comb begin
      a_t   = '0;
      b_t   = '0;
      op_t  = ALU_ADD;
      legal = 1'b0;
      case (opcode)
         OPC_OP: begin
            a_t = rs1;
            b_t = rs2;
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               op_t  = f3_base_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               legal = 1'b1;
               op_t  = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
               legal = 1'b1;
               op_t  = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            a_t = rs1;
            case (funct3)
               F3_SLL: begin
                  b_t = {27'b0, instr[24:20]};
                  if (funct7 == F7_BASE) begin
                     legal = 1'b1;
                     op_t  = ALU_SLL;
                  end
               end
               F3_SR: begin
                  b_t = {27'b0, instr[24:20]};
                  if (funct7 == F7_BASE) begin
                     legal = 1'b1;
                     op_t  = ALU_SRL;
                  end else if (funct7 == F7_ALT) begin
                     legal = 1'b1;
                     op_t  = ALU_SRA;
                  end
               end
               default: begin
                  b_t   = imm_i;
                  legal = 1'b1;
                  op_t  = f3_base_op(funct3);
               end
            endcase
         end
         OPC_LUI: begin
            b_t   = imm_u;
            legal = 1'b1;
         end
         OPC_AUIPC: begin
            a_t   = pc;
            b_t   = imm_u;
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Unsupported encodings are squashed to a harmless ADD 0,0 writing x0.
   assign a       = legal ? a_t : '0;
   assign b       = legal ? b_t : '0;
   assign op      = legal ? op_t : ALU_ADD;
   assign rd      = legal ? instr[11:7] : 5'd0;
   assign illegal = ~legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one valid/ready register slice holding the decoded operands for the ALU.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_alu_op,
   output logic [4:0]  out_rd,
   output logic        out_illegal
);

   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [4:0]  dec_op;
   logic [4:0]  dec_rd;
   logic        dec_illegal;
   logic        xfer;

   alu_decode u_decode (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1     (in_rs1_data),
      .rs2     (in_rs2_data),
      .a       (dec_a),
      .b       (dec_b),
      .op      (dec_op),
      .rd      (dec_rd),
      .illegal (dec_illegal)
   );

   assign in_ready = ~out_valid | out_ready;
   assign xfer     = in_valid & in_ready & ~flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_a       <= '0;
         out_b       <= '0;
         out_alu_op  <= ALU_ADD;
         out_rd      <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_valid   <= 1'b1;
         out_a       <= dec_a;
         out_b       <= dec_b;
         out_alu_op  <= dec_op;
         out_rd      <= dec_rd;
         out_illegal <= dec_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: per-cycle model comparison plus directed literal checks.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_alu_op;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_alu_op  (out_alu_op),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      logic [4:0]  rd;
      logic        ill;
   } dec_t;

   // ALU codes indexed by funct3 for the base (funct7 = 0) register-register forms.
   logic [4:0] op_by_f3 [8] = '{5'd0, 5'd1, 5'd12, 5'd14, 5'd4, 5'd5, 5'd6, 5'd7};

   function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      dec_t d;
      int unsigned f3, f7, opc;
      logic ok;
      opc = i[6:0];
      f3  = i[14:12];
      f7  = i[31:25];
      d   = '0;
      ok  = 1'b0;
      if (opc == 'h33) begin
         d.a = r1;
         d.b = r2;
         if (f7 == 0) begin ok = 1; d.op = op_by_f3[f3]; end
         else if (f7 == 'h20 && f3 == 0) begin ok = 1; d.op = 5'd10; end
         else if (f7 == 'h20 && f3 == 5) begin ok = 1; d.op = 5'd11; end
      end else if (opc == 'h13) begin
         d.a = r1;
         if (f3 == 1 || f3 == 5) begin
            d.b = 32'(i[24:20]);
            if (f7 == 0) begin ok = 1; d.op = op_by_f3[f3]; end
            else if (f7 == 'h20 && f3 == 5) begin ok = 1; d.op = 5'd11; end
         end else begin
            ok  = 1;
            d.b = 32'($signed(i[31:20]));
            d.op = op_by_f3[f3];
         end
      end else if (opc == 'h37) begin
         ok = 1; d.a = 0; d.b = i & 32'hFFFFF000;
      end else if (opc == 'h17) begin
         ok = 1; d.a = pc; d.b = i & 32'hFFFFF000;
      end
      if (ok) d.rd = i[11:7];
      else d = '{a: 0, b: 0, op: 0, rd: 0, ill: 1'b1};
      return d;
   endfunction

   // Reference: a one-entry slot; what was last accepted is what the ALU must see.
   logic m_init = 1'b0;
   logic m_full = 1'b0;
   logic m_fields_known = 1'b0;
   dec_t m_entry;

   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         m_init = 1'b1;
         m_full = 1'b0;
         m_entry = '0;
         m_fields_known = 1'b1;
      end else if (m_init) begin
         logic taken, consumed;
         consumed = m_full && out_ready;
         taken    = in_valid && (!m_full || out_ready) && !flush;
         if (flush) m_full = 1'b0;
         else if (taken) begin
            m_entry = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
            m_full = 1'b1;
            m_fields_known = 1'b1;
         end else if (consumed) m_full = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("model_out_valid", 32'(out_valid), 32'(m_full));
         chk("model_in_ready", 32'(in_ready), 32'(!m_full || out_ready));
         if (m_full || m_fields_known) begin
            chk("model_a", out_a, m_entry.a);
            chk("model_b", out_b, m_entry.b);
            chk("model_op", 32'(out_alu_op), 32'(m_entry.op));
            chk("model_rd", 32'(out_rd), 32'(m_entry.rd));
            chk("model_ill", 32'(out_illegal), 32'(m_entry.ill));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step(); step();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_a", out_a, 0);
      chk("rst_op", 32'(out_alu_op), 0);
      chk("rst_ill", 32'(out_illegal), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      rst_n = 1'b1;
      drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
      step();
      chk("add_valid", 32'(out_valid), 1);
      chk("add_a", out_a, 5);
      chk("add_b", out_b, 7);
      chk("add_op", 32'(out_alu_op), 0);
      chk("add_rd", 32'(out_rd), 3);

      drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd7);
      step();
      chk("sub_op", 32'(out_alu_op), 32'h0A);
      chk("sub_in_ready", 32'(in_ready), 1);
      drive(1'b1, 32'hFFF08293, 32'h0, 32'd10, 32'd7);
      step();
      chk("addi_op", 32'(out_alu_op), 0);
      chk("addi_b", out_b, 32'hFFFFFFFF);
      chk("addi_rd", 32'(out_rd), 5);
      chk("addi_in_ready", 32'(in_ready), 1);

      drive(1'b1, 32'h4030D213, 32'h0, 32'd10, 32'd0);
      step();
      chk("srai_op", 32'(out_alu_op), 32'h0B);
      chk("srai_b", out_b, 3);
      chk("srai_rd", 32'(out_rd), 4);
      drive(1'b1, 32'h2030D213, 32'h0, 32'd10, 32'd0);
      step();
      chk("srai_bad_ill", 32'(out_illegal), 1);
      chk("srai_bad_a", out_a, 0);
      chk("srai_bad_b", out_b, 0);

      drive(1'b1, 32'h123452B7, 32'h0, 32'd9, 32'd9);
      step();
      chk("lui_a", out_a, 0);
      chk("lui_b", out_b, 32'h12345000);
      drive(1'b1, 32'h00001317, 32'h100, 32'd9, 32'd9);
      step();
      chk("auipc_a", out_a, 32'h100);
      chk("auipc_b", out_b, 32'h1000);
      chk("auipc_rd", 32'(out_rd), 6);
      drive(1'b1, 32'h0020E1B3, 32'h0, 32'hF0, 32'h0F);
      step();
      chk("or_op", 32'(out_alu_op), 32'h06);
      drive(1'b1, 32'hFFB0B393, 32'h0, 32'd1, 32'd0);
      step();
      chk("sltiu_op", 32'(out_alu_op), 32'h0E);
      chk("sltiu_b", out_b, 32'hFFFFFFFB);
      drive(1'b1, 32'h0000007F, 32'h0, 32'd1, 32'd2);
      step();
      chk("badopc_ill", 32'(out_illegal), 1);
      drive(1'b1, 32'h022081B3, 32'h0, 32'd1, 32'd2);
      step();
      chk("mul_ill", 32'(out_illegal), 1);
      chk("mul_rd", 32'(out_rd), 0);

      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      chk("drain_valid", 32'(out_valid), 0);
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
      step();
      drive(1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_a", out_a, 1);
         chk("stall_valid", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      step();
      chk("release_a", out_a, 9);
      chk("release_op", 32'(out_alu_op), 32'h0A);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      chk("release_once", 32'(out_valid), 0);

      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h0, 32'd3, 32'd3);
      step();
      drive(1'b1, 32'h402081B3, 32'h0, 32'h55, 32'd1);
      out_ready = 1'b1; flush = 1'b1;
      step();
      chk("flush_valid", 32'(out_valid), 0);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      chk("flush_no_ghost", 32'(out_valid), 0);

      out_ready = 1'b0;
      drive(1'b1, 32'h123452B7, 32'h0, 32'd0, 32'd0);
      step();
      drive(1'b1, 32'h0020E1B3, 32'h0, 32'hF0, 32'h0F);
      rst_n = 1'b0;
      step();
      chk("rst_stall_valid", 32'(out_valid), 0);
      chk("rst_stall_a", out_a, 0);
      chk("rst_stall_op", 32'(out_alu_op), 0);
      rst_n = 1'b1;
      chk("rst_stall_in_ready", 32'(in_ready), 1);
      step();
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_op", 32'(out_alu_op), 32'h06);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      out_ready = 1'b1;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
